// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
//   Bundles the IF->ID queue handshake and data signals.
//
//   Fetch side : in_valid, in_pc, in_instr  ->  queue ;  in_ready  <- queue
//   Decode side: out_valid, out_pc, out_instr <- queue ; out_ready -> queue
//   Control    : flush (branch taken) -> queue ;  count <- queue
//
//   Modports
//     slave  : the queue itself
//     master : the surrounding pipeline (or a testbench) driving the queue
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   FIFO between instruction fetch and decode. Holds DEPTH {pc, instr}
//   pairs, delivered in strict push order. A flush (taken branch) empties
//   the queue at the next edge; rst empties it and dominates everything.
//
//   Ports
//     clk   : single clock, rising edge
//     rst   : synchronous, active-high reset
//     q     : if_id_queue_if.slave
//             in_valid/in_pc/in_instr/in_ready   fetch handshake (in_ready = PCWrite)
//             out_valid/out_pc/out_instr/out_ready decode handshake
//             flush                               discard all queued entries
//             count                               number of stored entries
//
//   Parameter
//     DEPTH : entries, power of two in 2..16
//
//   Optional feature (macro IF_ID_QUEUE_BYPASS_EN)
//     When defined, an empty queue forwards in_* straight to out_* in the
//     same cycle; if decode takes it (out_ready = 1) it is not stored.
//     When undefined there is no combinational in-to-out path and a pushed
//     entry appears on out_* the cycle after the push.
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    if_id_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Storage is intentionally not reset: it is unobservable while count = 0.
    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic        head_valid;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        push;
    logic        pop;
    logic        store;
    logic        dequeue;

    // -----------------------------------------------------------------------
    // Handshake and output selection
    // -----------------------------------------------------------------------
    assign head_valid = (count_q != CNT_ZERO);
    assign in_ready   = (count_q != CNT_FULL);

    always_comb begin
        out_valid = 1'b0;
        out_pc    = 32'h0;
        out_instr = 32'h0;
        // Flush kills the head in the flush cycle itself.
        if (!q.flush) begin
            if (head_valid) begin
                out_valid = 1'b1;
                out_pc    = pc_mem_q[rd_ptr_q];
                out_instr = instr_mem_q[rd_ptr_q];
            end
`ifdef IF_ID_QUEUE_BYPASS_EN
            else if (q.in_valid) begin
                out_valid = 1'b1;
                out_pc    = q.in_pc;
                out_instr = q.in_instr;
            end
`endif
        end
    end

    assign push = q.in_valid && in_ready && !q.flush;
    assign pop  = out_valid && q.out_ready && !q.flush;

    // A pop with nothing stored can only be a bypassed entry: it was pushed
    // and consumed in the same cycle, so neither storage nor count moves.
    assign store   = push && !(pop && !head_valid);
    assign dequeue = pop && head_valid;

    // -----------------------------------------------------------------------
    // Next-state for pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (q.flush) begin
            // Nothing is retained; equalizing the pointers is sufficient.
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_ZERO;
        end else begin
            // Pointers are exactly PTR_W bits wide, so increments wrap mod DEPTH.
            if (store)   wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (dequeue) rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({store, dequeue})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store && !rst) begin
            pc_mem_q[wr_ptr_q]    <= q.in_pc;
            instr_mem_q[wr_ptr_q] <= q.in_instr;
        end
    end

    assign q.in_ready  = in_ready;
    assign q.out_valid = out_valid;
    assign q.out_pc    = out_pc;
    assign q.out_instr = out_instr;
    assign q.count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
//   Directed bench for if_id_queue with DEPTH = 4. Inputs change 1 time unit
//   after the rising edge; outputs are sampled 1 more unit later, well away
//   from the next edge. Instruction words are derived from the PC so the
//   pc/instr pairing is checked along with order.
// ---------------------------------------------------------------------------
module tb_if_id_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    if_id_queue_if #(.DEPTH(DEPTH)) ifc ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        ifc.in_valid  = v;
        ifc.in_pc     = pc;
        ifc.in_instr  = mk_instr(pc);
        ifc.out_ready = rdy;
        ifc.flush     = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_pc",    ifc.out_pc,         32'h0);
        chk("rst_out_instr", ifc.out_instr,      32'h0);
        chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        chk("rst_count",     32'(ifc.count),     32'd0);

        // Single push, decode stalled.
        ifc.in_valid  = 1'b1;
        ifc.in_pc     = 32'h0;
        ifc.in_instr  = 32'h0050_0093;
        ifc.out_ready = 1'b0;
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        chk("p1_bypass_valid", 32'(ifc.out_valid), 32'd1);
        chk("p1_bypass_instr", ifc.out_instr,      32'h0050_0093);
`else
        chk("p1_same_cycle_valid", 32'(ifc.out_valid), 32'd0);
`endif
        cyc();
        ifc.in_valid = 1'b0;
        #1;
        chk("p1_out_valid", 32'(ifc.out_valid), 32'd1);
        chk("p1_out_pc",    ifc.out_pc,         32'h0);
        chk("p1_out_instr", ifc.out_instr,      32'h0050_0093);
        chk("p1_count",     32'(ifc.count),     32'd1);
        ifc.out_ready = 1'b1;
        cyc();
        ifc.out_ready = 1'b0;
        #1;
        chk("p1_drained_count", 32'(ifc.count), 32'd0);

        // Fill to DEPTH, then a rejected fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        #1;
        chk("full_count",    32'(ifc.count),    32'd4);
        chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("fifth_count", 32'(ifc.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            chk("drain_pc",    ifc.out_pc,    32'(4 * i));
            chk("drain_instr", ifc.out_instr, mk_instr(32'(4 * i)));
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("drain_count", 32'(ifc.count),     32'd0);
        chk("drain_valid", 32'(ifc.out_valid), 32'd0);

        // Refill; at full a push+pop only pops (no pop-through).
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h20 + 32'(4 * i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h30, 1'b1, 1'b0);
        #1;
        chk("pt_head_pc", ifc.out_pc, 32'h20);
        cyc();
        #1;
        chk("pt_count", 32'(ifc.count), 32'd3);
        // Six cycles of simultaneous push and pop: count holds, pointers wrap.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h30 + 32'(4 * i), 1'b1, 1'b0);
            #1;
            chk("pp_out_pc",    ifc.out_pc,     32'h24 + 32'(4 * i));
            chk("pp_out_instr", ifc.out_instr,  mk_instr(32'h24 + 32'(4 * i)));
            chk("pp_count",     32'(ifc.count), 32'd3);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pp_end_count", 32'(ifc.count), 32'd3);
        chk("pp_end_head",  ifc.out_pc,     32'h3C);

        // Flush with a concurrent push: killed this cycle, empty next.
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        #1;
        chk("fl_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("fl_out_pc",    ifc.out_pc,         32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("fl_next_count",    32'(ifc.count),     32'd0);
        chk("fl_next_valid",    32'(ifc.out_valid), 32'd0);
        chk("fl_next_in_ready", 32'(ifc.in_ready),  32'd1);
        drive(1'b1, 32'h80, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("fl_push_valid", 32'(ifc.out_valid), 32'd1);
        chk("fl_push_pc",    ifc.out_pc,         32'h80);
        chk("fl_push_count", 32'(ifc.count),     32'd1);

        // Reset mid-operation, dominating flush/push/pop.
        drive(1'b1, 32'h84, 1'b0, 1'b0);
        cyc();
        #1;
        chk("rs_pre_count", 32'(ifc.count), 32'd2);
        drive(1'b1, 32'h88, 1'b1, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rs_count",     32'(ifc.count),     32'd0);
        chk("rs_out_pc",    ifc.out_pc,         32'h0);
        chk("rs_in_ready",  32'(ifc.in_ready),  32'd1);
        chk("rs_out_valid", 32'(ifc.out_valid), 32'd0);

        // Empty queue, push with decode ready.
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        chk("bp_out_pc",    ifc.out_pc,         32'h10);
        chk("bp_out_instr", ifc.out_instr,      mk_instr(32'h10));
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bp_count", 32'(ifc.count), 32'd0);
`else
        chk("nb_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("nb_out_pc",    ifc.out_pc,         32'h0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("nb_count",  32'(ifc.count), 32'd1);
        chk("nb_head",   ifc.out_pc,     32'h10);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
